// File: rtl/parity_frame_pkg.sv
// Shared types and line levels for the parity serial framer.
// Optional build macro: ODD_PARITY_EN (odd instead of even parity bit).
package parity_frame_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } tx_state_t;

   localparam logic TX_IDLE_LVL = 1'b1;
   localparam logic START_LVL   = 1'b0;
   localparam logic STOP_LVL    = 1'b1;

endpackage

// File: rtl/frame_parity_calc.sv
// Combinational parity of the latched frame word.
// Build macro ODD_PARITY_EN selects odd parity; default is even parity.
module frame_parity_calc
   import parity_frame_pkg::*;
#(
   parameter int DATA_W = 4
) (
   input  logic [DATA_W-1:0] data_i,
   output logic              parity_o
);

`ifdef ODD_PARITY_EN
   assign parity_o = ~(^data_i);
`else
   assign parity_o = ^data_i;
`endif

endmodule

// File: rtl/parity_frame_tx.sv
// Serial framer: start bit, data LSB-first, parity bit, stop bit, each BIT_CYCLES clocks.
// Build macro ODD_PARITY_EN (via frame_parity_calc) switches the parity sense.
module parity_frame_tx
   import parity_frame_pkg::*;
#(
   parameter int DATA_W     = 4,
   parameter int BIT_CYCLES = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              tx,
   output logic              busy,
   output logic              done
);

   localparam int CNT_W = $clog2(BIT_CYCLES) + 1;
   localparam int IDX_W = $clog2(DATA_W) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_CYCLES - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

   tx_state_t         state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              tx_q, tx_d;
   logic              parity;
   logic              bit_last;
   logic              accept;
   logic [DATA_W-1:0] data_shift;

   frame_parity_calc #(
      .DATA_W (DATA_W)
   ) u_parity (
      .data_i   (data_q),
      .parity_o (parity)
   );

   assign bit_last = (cnt_q == CNT_LAST);
   assign in_ready = (state_q == IDLE) || ((state_q == STOP) && bit_last);
   assign accept   = in_valid && in_ready;
   assign busy     = (state_q != IDLE);
   assign done     = (state_q == STOP) && bit_last;
   assign tx       = tx_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = bit_last ? '0 : cnt_q + CNT_W'(1);
      idx_d   = idx_q;
      data_d  = data_q;
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (accept) begin
               state_d = START;
               data_d  = in_data;
            end
         end
         START: begin
            if (bit_last) begin
               state_d = DATA;
            end
         end
         DATA: begin
            if (bit_last) begin
               if (idx_q == IDX_LAST) begin
                  state_d = PARITY;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end
         end
         PARITY: begin
            if (bit_last) begin
               state_d = STOP;
            end
         end
         STOP: begin
            if (bit_last) begin
               if (accept) begin
                  state_d = START;
                  data_d  = in_data;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      if (state_d != state_q) begin
         cnt_d = '0;
      end
      if (state_d != DATA) begin
         idx_d = '0;
      end
   end

   // tx is registered, so it is derived from the next state to line up with it
   assign data_shift = data_q >> idx_d;

   always_comb begin
      tx_d = TX_IDLE_LVL;
      case (state_d)
         IDLE:    tx_d = TX_IDLE_LVL;
         START:   tx_d = START_LVL;
         DATA:    tx_d = data_shift[0];
         PARITY:  tx_d = parity;
         STOP:    tx_d = STOP_LVL;
         default: tx_d = TX_IDLE_LVL;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         data_q  <= '0;
         tx_q    <= TX_IDLE_LVL;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         data_q  <= data_d;
         tx_q    <= tx_d;
      end
   end

endmodule
